// File: rtl/alu_32_if.sv
// Operand/result bundle for alu_32: the requester drives sel/a/b, the ALU
// returns result and zero_bit.
interface alu_32_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero_bit;

  modport master (output sel, a, b, input result, zero_bit);
  modport slave  (input sel, a, b, output result, zero_bit);
endinterface

// File: rtl/alu_32.sv
// 8-function ALU: seven combinational ops plus an unsigned modulo computed by a
// free-running repeated-subtraction FSM whose remainder is shown on sel=7.
module alu_32 #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_32_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } mod_state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOR = 3'd3,
    OP_SLT = 3'd4,
    OP_ADD = 3'd5,
    OP_SUB = 3'd6,
    OP_MOD = 3'd7
  } op_e;

  mod_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] la_q, la_d;
  logic [WIDTH-1:0] lb_q, lb_d;
  logic [WIDTH-1:0] result_d;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; combinational logic uses blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      rem_q   <= '0;
      la_q    <= '0;
      lb_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    la_d    = la_q;
    lb_d    = lb_q;
    unique case (state_q)
      LOAD: begin
        rem_d   = bus.a;
        la_d    = bus.a;
        lb_d    = bus.b;
        state_d = SUB;
      end
      SUB: begin
        // a mod 0 is defined as a, so a zero divisor ends immediately.
        if (lb_q == '0) begin
          state_d = DONE;
        end else if (rem_q >= lb_q) begin
          rem_d = rem_q - lb_q;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if ((bus.a != la_q) || (bus.b != lb_q)) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    result_d = '0;
    unique case (op_e'(bus.sel))
      OP_AND:  result_d = bus.a & bus.b;
      OP_OR:   result_d = bus.a | bus.b;
      OP_XOR:  result_d = bus.a ^ bus.b;
      OP_NOR:  result_d = ~(bus.a | bus.b);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_ADD:  result_d = bus.a + bus.b;
      OP_SUB:  result_d = bus.a - bus.b;
      OP_MOD:  result_d = rem_q;
      default: result_d = '0;
    endcase
  end

  assign bus.result   = result_d;
  assign bus.zero_bit = (result_d == '0);

endmodule

// File: tb/tb_alu_32.sv
// Directed-vector bench for alu_32: combinational ops, signed compare, wrap,
// and the modulo FSM across reset, restart, divide-by-zero and mid-op reset.
module tb_alu_32;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_32_if #(.WIDTH(WIDTH)) bus ();

  alu_32 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    bus.sel = 3'd7;
    bus.a   = 32'd10;
    bus.b   = 32'd3;
    wait_cycles(50);
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %0d expected 0", bus.result);
    end
    n_checks++;
    if (bus.zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_zero: got %b expected 1", bus.zero_bit);
    end
    reset = 1'b0;
    wait_cycles(6);
    n_checks++;
    if (bus.result !== 32'd1) begin
      n_fail++;
      $display("FAIL mod_10_3: got %0d expected 1", bus.result);
    end
    n_checks++;
    if (bus.zero_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_10_3_zero: got %b expected 0", bus.zero_bit);
    end
  endtask

  task automatic test_logic_ops;
    logic [WIDTH-1:0] exp_r;
    logic             exp_z;
    bus.a = 32'd10;
    bus.b = 32'd3;
    for (int s = 0; s < 7; s++) begin
      case (s)
        0:       begin exp_r = 32'd2;          exp_z = 1'b0; end
        1:       begin exp_r = 32'd11;         exp_z = 1'b0; end
        2:       begin exp_r = 32'd9;          exp_z = 1'b0; end
        3:       begin exp_r = 32'hFFFF_FFF4;  exp_z = 1'b0; end
        4:       begin exp_r = 32'd0;          exp_z = 1'b1; end
        5:       begin exp_r = 32'd13;         exp_z = 1'b0; end
        default: begin exp_r = 32'd7;          exp_z = 1'b0; end
      endcase
      bus.sel = 3'(s);
      #1;
      n_checks++;
      if (bus.result !== exp_r) begin
        n_fail++;
        $display("FAIL op%0d_result: got %h expected %h", s, bus.result, exp_r);
      end
      n_checks++;
      if (bus.zero_bit !== exp_z) begin
        n_fail++;
        $display("FAIL op%0d_zero: got %b expected %b", s, bus.zero_bit, exp_z);
      end
    end
  endtask

  task automatic test_slt_signed;
    bus.sel = 3'd4;
    bus.a   = 32'hFFFF_FFFF;
    bus.b   = 32'd1;
    #1;
    n_checks++;
    if (bus.result !== 32'd1) begin
      n_fail++;
      $display("FAIL slt_neg1_lt_1: got %0d expected 1", bus.result);
    end
    bus.a = 32'd1;
    bus.b = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL slt_1_lt_neg1: got %0d expected 0", bus.result);
    end
  endtask

  task automatic test_wrap;
    bus.sel = 3'd5;
    bus.a   = 32'hFFFF_FFFF;
    bus.b   = 32'd1;
    #1;
    n_checks++;
    if (bus.result !== 32'd0 || bus.zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: got %h/%b expected 00000000/1", bus.result, bus.zero_bit);
    end
    bus.sel = 3'd6;
    bus.a   = 32'd0;
    bus.b   = 32'd1;
    #1;
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFF || bus.zero_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_wrap: got %h/%b expected ffffffff/0", bus.result, bus.zero_bit);
    end
  endtask

  task automatic test_mod_restart;
    @(negedge clk);
    bus.sel = 3'd7;
    bus.a   = 32'd10;
    bus.b   = 32'd3;
    wait_cycles(8);
    bus.a = 32'd100;
    bus.b = 32'd7;
    wait_cycles(16);
    n_checks++;
    if (bus.result !== 32'd2) begin
      n_fail++;
      $display("FAIL mod_100_7: got %0d expected 2", bus.result);
    end
    bus.a = 32'd55;
    bus.b = 32'd0;
    wait_cycles(6);
    n_checks++;
    if (bus.result !== 32'd55) begin
      n_fail++;
      $display("FAIL mod_55_0: got %0d expected 55", bus.result);
    end
    bus.a = 32'd21;
    bus.b = 32'd7;
    wait_cycles(8);
    n_checks++;
    if (bus.result !== 32'd0 || bus.zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_21_7: got %0d/%b expected 0/1", bus.result, bus.zero_bit);
    end
    bus.sel = 3'd0;
    wait_cycles(2);
    bus.sel = 3'd7;
    #1;
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL mod_sel_switch: got %0d expected 0", bus.result);
    end
  endtask

  task automatic test_reset_mid_mod;
    @(negedge clk);
    bus.sel = 3'd7;
    bus.a   = 32'd1000;
    bus.b   = 32'd1;
    wait_cycles(10);
    n_checks++;
    if (bus.result === 32'd0) begin
      n_fail++;
      $display("FAIL mid_mod_busy: got %0d expected nonzero", bus.result);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.result !== 32'd0 || bus.zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got %0d/%b expected 0/1", bus.result, bus.zero_bit);
    end
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(500);
    n_checks++;
    if (bus.result !== 32'd501) begin
      n_fail++;
      $display("FAIL mod_1000_1_mid: got %0d expected 501", bus.result);
    end
    wait_cycles(510);
    n_checks++;
    if (bus.result !== 32'd0 || bus.zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_1000_1: got %0d/%b expected 0/1", bus.result, bus.zero_bit);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.sel  = 3'd0;
    bus.a    = '0;
    bus.b    = '0;
    test_reset();
    test_logic_ops();
    test_slt_signed();
    test_wrap();
    test_mod_restart();
    test_reset_mid_mod();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit, 8-function ALU for the datapath.
- Seven functions are purely combinational: AND, OR, XOR, NOR, set-less-than, add and subtract.
- The eighth function, unsigned modulo, is computed by an internal clocked FSM using repeated subtraction.
- A zero flag reports when the selected result is zero.

Parameters:
- WIDTH, 32, operand/result width (the Behaviour and Test Plan values assume 32).

Ports:
- clk       input   1      system clock, rising-edge
- reset     input   1      asynchronous, active-high reset; clears the modulo FSM
- result    output  WIDTH  selected function output
- zero_bit  output  1      1 when result == 0, else 0
- sel       input   3      function select
- a         input   WIDTH  operand A
- b         input   WIDTH  operand B

Behaviour:
- The interface uses one clock, clk. Reset is asynchronous and active-high, named reset.
- The sel encoding is below. Ops 0-6 are combinational: result follows a/b/sel in the same cycle.
  - 0 = a AND b
  - 1 = a OR b
  - 2 = a XOR b
  - 3 = NOR, i.e. ~(a | b)
  - 4 = set-less-than: signed two's-complement compare; result = 1 if a < b, else 0 (zero-extended)
  - 5 = a + b, modulo 2^WIDTH; carry/overflow discarded, no flags
  - 6 = a - b, modulo 2^WIDTH; borrow discarded
  - 7 = a mod b, unsigned, from the FSM remainder register
- zero_bit = (result == 0), combinational from the muxed result, valid for all sel values.
- Modulo FSM runs continuously, independent of sel. It has a remainder register rem, latched copies la/lb, and states LOAD, SUB, DONE.
- Reset (async):
  - state = LOAD, rem = 0, la = 0, lb = 0.
  - With sel=7 during reset, result = 0 and zero_bit = 1.
- LOAD: rem <= a, la <= a, lb <= b; next state SUB.
- SUB:
  - if lb == 0: next DONE, rem unchanged (a mod 0 is defined as a).
  - else if rem >= lb: rem <= rem - lb, stay in SUB.
  - else: next DONE.
- DONE: rem holds.
  - If a != la or b != lb, next state LOAD (automatic restart on operand change).
- Latency of mod: floor(a/b) + 2 cycles from a stable operand change or from reset deassert.
  - While the FSM is in LOAD/SUB, result for sel=7 shows the intermediate rem.
  - Consumers wait for completion; no done/valid output is provided.
- Operand change during SUB is not detected until DONE; the FSM then restarts via LOAD.
- Reset mid-operation aborts immediately to LOAD with rem = 0.
- Switching sel does not disturb the FSM.
- No other internal state; ops 0-6 are unaffected by reset.

Test Plan:
- a=10, b=3, sel=0..6, one vector per sel value. Required result and zero_bit for each:
  - sel=0: result 2, zero_bit 0
  - sel=1: result 11, zero_bit 0
  - sel=2: result 9, zero_bit 0
  - sel=3: result 4294967284 (0xFFFFFFF4), zero_bit 0
  - sel=4: result 0, zero_bit 1
  - sel=5: result 13, zero_bit 0
  - sel=6: result 7, zero_bit 0
- a=10, b=3, sel=7; pulse reset high 50 cycles, then release; wait >= 6 cycles -> result 1, zero_bit 0. During reset, result 0 and zero_bit 1.
- Signed SLT: a=0xFFFFFFFF (-1), b=1, sel=4 -> result 1. Then swap a and b -> result 0.
- Wrap: a=0xFFFFFFFF, b=1, sel=5 -> result 0, zero_bit 1. Then sel=6, a=0, b=1 -> result 0xFFFFFFFF.
- Mod restart and divide-by-zero:
  - After the 10 mod 3 result settles, change to a=100, b=7 -> within 16 cycles result 2.
  - Then b=0, a=55 -> result 55.
  - Then a=21, b=7 -> result 0, zero_bit 1.
- Reset mid-mod: a=1000, b=1, sel=7; assert reset at cycle 10 (asynchronously, between edges) -> result drops to 0 immediately, without waiting for a clock edge. After release, result reaches 0 after about 1002 cycles; rem passes through intermediate values on the way.
